// File: rtl/uart_tx_reg.sv
// Memory-mapped UART transmitter: register file, TX FIFO and 8-bit serializer
// with optional parity and one or two stop bits.
//
//   state    | meaning
//   S_IDLE   | line idle high, waiting for EN and a queued byte
//   S_START  | start bit (0)
//   S_DATA   | eight data bits, LSB first
//   S_PARITY | parity bit, only when parity was enabled at the pop
//   S_STOP   | one or two stop bits (1)
module uart_tx_reg #(
  parameter int FIFO_DEPTH   = 8,
  parameter int BAUD_DEFAULT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        chipSelect,
  input  logic        write,
  input  logic        read,
  input  logic [3:0]  addr,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;

  logic [15:0]   baud_div;
  logic [4:0]    ctrl;
  logic          overflow;
  logic [7:0]    drop_cnt;

  state_t        state, state_nxt;
  logic [15:0]   baud_cnt, baud_cnt_nxt;
  logic [2:0]    bit_cnt, bit_cnt_nxt;
  logic [7:0]    shift, shift_nxt;
  logic          tx_nxt;
  logic          stop_second, stop_second_nxt;
  logic          frm_par_en, frm_stop2, par_bit;
  logic          start_frame, boundary, busy;

  logic          access, wr_en, push_req, pop, push_ok, push_drop;
  logic [7:0]    head;
  logic [31:0]   rd_val;
  logic          unused_bits;

  assign unused_bits = ^writeData[31:16];

  assign access    = chipSelect & en;
  assign wr_en     = access & write;
  assign push_req  = wr_en && (addr == 4'd0);
  assign full      = (count == CW'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign pop       = en & start_frame;
  // a full FIFO still accepts a byte when the serializer pops on the same edge
  assign push_ok   = push_req && (!full || pop);
  assign push_drop = push_req && !push_ok;
  assign head      = fifo_mem[rd_ptr];
  assign busy      = (state != S_IDLE);
  assign boundary  = (baud_cnt == 16'd1);
  assign irq       = empty && !busy && ctrl[4] && ctrl[0];

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= writeData[7:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_div <= 16'(BAUD_DEFAULT);
      ctrl     <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (en) begin
      if (wr_en) begin
        case (addr)
          4'd1: if (writeData[3]) overflow <= 1'b0;
          4'd2: baud_div <= (writeData[15:0] == 16'd0) ? 16'd1 : writeData[15:0];
          4'd3: ctrl <= writeData[4:0];
          4'd4: drop_cnt <= '0;
          default: ;
        endcase
      end
      if (push_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  always_comb begin
    rd_val = '0;
    case (addr)
      4'd1: rd_val = {16'b0, 8'(count), 4'b0, overflow, empty, full, busy};
      4'd2: rd_val = {16'b0, baud_div};
      4'd3: rd_val = {27'b0, ctrl};
      4'd4: rd_val = {24'b0, drop_cnt};
      default: rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 readData <= '0;
    else if (access && read)  readData <= rd_val;
  end

  always_comb begin
    state_nxt       = state;
    baud_cnt_nxt    = baud_cnt;
    bit_cnt_nxt     = bit_cnt;
    shift_nxt       = shift;
    tx_nxt          = tx;
    stop_second_nxt = stop_second;
    start_frame     = 1'b0;
    if (state != S_IDLE) begin
      // reload from the live divisor so a BAUD write lands on the next bit
      baud_cnt_nxt = boundary ? baud_div : baud_cnt - 16'd1;
    end
    case (state)
      S_IDLE: start_frame = ctrl[0] && !empty;
      S_START: begin
        if (boundary) begin
          state_nxt   = S_DATA;
          bit_cnt_nxt = 3'd0;
          tx_nxt      = shift[0];
        end
      end
      S_DATA: begin
        if (boundary) begin
          if (bit_cnt == 3'd7) begin
            if (frm_par_en) begin
              state_nxt = S_PARITY;
              tx_nxt    = par_bit;
            end else begin
              state_nxt       = S_STOP;
              tx_nxt          = 1'b1;
              stop_second_nxt = 1'b0;
            end
          end else begin
            shift_nxt   = {1'b0, shift[7:1]};
            tx_nxt      = shift[1];
            bit_cnt_nxt = bit_cnt + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (boundary) begin
          state_nxt       = S_STOP;
          tx_nxt          = 1'b1;
          stop_second_nxt = 1'b0;
        end
      end
      S_STOP: begin
        if (boundary) begin
          if (frm_stop2 && !stop_second) begin
            stop_second_nxt = 1'b1;
          end else begin
            state_nxt   = S_IDLE;
            tx_nxt      = 1'b1;
            start_frame = ctrl[0] && !empty;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (start_frame) begin
      state_nxt    = S_START;
      shift_nxt    = head;
      baud_cnt_nxt = baud_div;
      tx_nxt       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      baud_cnt    <= '0;
      bit_cnt     <= '0;
      shift       <= '0;
      tx          <= 1'b1;
      stop_second <= 1'b0;
      frm_par_en  <= 1'b0;
      frm_stop2   <= 1'b0;
      par_bit     <= 1'b0;
    end else if (en) begin
      state       <= state_nxt;
      baud_cnt    <= baud_cnt_nxt;
      bit_cnt     <= bit_cnt_nxt;
      shift       <= shift_nxt;
      tx          <= tx_nxt;
      stop_second <= stop_second_nxt;
      if (start_frame) begin
        frm_par_en <= ctrl[1];
        frm_stop2  <= ctrl[3];
        par_bit    <= (^head) ^ ctrl[2];
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_reg.sv
// Directed sequence with random payloads; tx is compared cycle by cycle against
// a waveform built from the frame format (start, data LSB first, parity, stops).
module tb_uart_tx_reg;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b1;
  logic        chipSelect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] writeData = '0;
  logic [31:0] readData;
  logic        tx, irq;

  int ncmp = 0;
  int nfail = 0;

  logic       wave[$];
  logic [7:0] mq[$];
  int         drops = 0;
  logic       ovf = 1'b0;

  always #5 clk = ~clk;

  uart_tx_reg #(.FIFO_DEPTH(DEPTH), .BAUD_DEFAULT(434)) dut (
    .clk(clk), .rst(rst), .en(en), .chipSelect(chipSelect), .write(write),
    .read(read), .addr(addr), .writeData(writeData), .readData(readData),
    .tx(tx), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_status(input bit busy);
    return {16'b0, 8'(mq.size()), 4'b0, ovf, mq.size() == 0, mq.size() == DEPTH, busy};
  endfunction

  // all bus tasks start and end on a falling edge and span one rising edge
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    chipSelect = 1'b1; write = 1'b1; read = 1'b0; addr = a; writeData = d;
    @(negedge clk);
    chipSelect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    chipSelect = 1'b1; read = 1'b1; write = 1'b0; addr = a;
    @(negedge clk);
    d = readData;
    chipSelect = 1'b0; read = 1'b0;
  endtask

  task automatic add_frame(input logic [7:0] b, input bit pe, input bit po,
                           input bit s2, input int baud);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (pe) bits.push_back((($countones(b) + int'(po)) % 2) == 1);
    bits.push_back(1'b1);
    if (s2) bits.push_back(1'b1);
    foreach (bits[k]) repeat (baud) wave.push_back(bits[k]);
  endtask

  // wave[i] is the line level during the i-th cycle after the pop edge
  task automatic run_wave(input int first, input int last, input bit chk_busy);
    if (chk_busy) begin
      chipSelect = 1'b1; read = 1'b1; write = 1'b0; addr = 4'd1;
    end
    for (int i = first; i <= last; i++) begin
      @(negedge clk);
      check($sformatf("tx[%0d]", i), 32'(tx), 32'(wave[i]));
      if (chk_busy && i >= first + 1) check($sformatf("busy[%0d]", i), 32'(readData[0]), 32'd1);
    end
    chipSelect = 1'b0; read = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, r;
    logic [7:0]  b, b2, first_b;
    logic [4:0]  cfg;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_readData", readData, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    bus_read(4'd1, rd); check("status_rst", rd, 32'h4);
    bus_read(4'd2, rd); check("baud_rst", rd, 32'd434);
    bus_read(4'd3, rd); check("ctrl_rst", rd, 32'd0);

    // BAUD register corner cases and read-during-write
    bus_write(4'd2, 32'd0);
    bus_read(4'd2, rd); check("baud_zero", rd, 32'd1);
    r = $urandom | 32'h1;
    chipSelect = 1'b1; write = 1'b1; read = 1'b1; addr = 4'd2; writeData = r;
    @(negedge clk);
    check("wr_rd_prewrite", readData, 32'd1);
    chipSelect = 1'b0; write = 1'b0; read = 1'b0;
    bus_read(4'd2, rd); check("baud_rw", rd, {16'b0, r[15:0]});
    bus_read(4'd0, rd); check("data_reads_zero", rd, 32'd0);
    bus_write(4'd9, 32'hFFFF_FFFF);
    bus_read(4'd9, rd); check("unmapped_zero", rd, 32'd0);

    // basic 8N1 frame, BAUD=4
    bus_write(4'd2, 32'd4);
    bus_write(4'd3, 32'h1);
    wave.delete();
    add_frame(8'h55, 1'b0, 1'b0, 1'b0, 4);
    bus_write(4'd0, 32'h55);
    run_wave(0, wave.size() - 1, 1'b1);
    @(negedge clk);
    bus_read(4'd1, rd); check("status_after_frame", rd, 32'h4);
    check("tx_idle", 32'(tx), 32'd1);

    // parity and stop-bit variants, BAUD=2
    bus_write(4'd2, 32'd2);
    for (int f = 0; f < 3; f++) begin
      if (f == 0)      begin cfg = 5'h07; b = 8'h03; end
      else if (f == 1) begin cfg = 5'h0F; b = 8'h03; end
      else begin
        cfg = {1'b0, 3'($urandom_range(0, 7)), 1'b1};
        b   = 8'($urandom);
      end
      bus_write(4'd3, 32'(cfg));
      wave.delete();
      add_frame(b, cfg[1], cfg[2], cfg[3], 2);
      bus_write(4'd0, 32'(b));
      run_wave(0, wave.size() - 1, 1'b0);
    end

    // overfill with EN=0
    bus_write(4'd3, 32'h0);
    mq.delete();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom);
      if (mq.size() < DEPTH) mq.push_back(b);
      else begin
        drops++;
        ovf = 1'b1;
      end
      bus_write(4'd0, 32'(b));
    end
    bus_read(4'd1, rd); check("status_full", rd, exp_status(1'b0));
    bus_read(4'd4, rd); check("dropcnt", rd, 32'(drops));
    bus_write(4'd1, 32'h8);
    ovf = 1'b0;
    bus_read(4'd1, rd); check("status_ovf_clr", rd, exp_status(1'b0));
    bus_read(4'd4, rd); check("dropcnt_kept", rd, 32'(drops));
    check("tx_no_en", 32'(tx), 32'd1);

    // push on the exact pop edge while full, then back-to-back drain
    chipSelect = 1'b1; write = 1'b1; read = 1'b0; addr = 4'd3; writeData = 32'h1;
    @(negedge clk);
    b = 8'($urandom);
    addr = 4'd0; writeData = 32'(b);
    @(negedge clk);
    first_b = mq.pop_front();
    mq.push_back(b);
    wave.delete();
    add_frame(first_b, 1'b0, 1'b0, 1'b0, 2);
    foreach (mq[k]) add_frame(mq[k], 1'b0, 1'b0, 1'b0, 2);
    check("tx[0]", 32'(tx), 32'(wave[0]));
    write = 1'b0; read = 1'b1; addr = 4'd1;
    @(negedge clk);
    check("status_pop_push", readData, exp_status(1'b1));
    check("tx[1]", 32'(tx), 32'(wave[1]));
    chipSelect = 1'b0; read = 1'b0;
    run_wave(2, wave.size() - 1, 1'b0);
    mq.delete();
    @(negedge clk);
    bus_read(4'd1, rd); check("status_drained", rd, 32'h4);
    bus_read(4'd4, rd); check("dropcnt_pop_push", rd, 32'(drops));
    bus_write(4'd3, 32'h11);
    check("irq_on", 32'(irq), 32'd1);

    // en=0 freeze mid-DATA, ignored bus writes, resume
    bus_write(4'd3, 32'h1);
    check("irq_off", 32'(irq), 32'd0);
    bus_write(4'd2, 32'd3);
    b = 8'($urandom);
    wave.delete();
    add_frame(b, 1'b0, 1'b0, 1'b0, 3);
    bus_write(4'd0, 32'(b));
    run_wave(0, 9, 1'b0);
    en = 1'b0;
    chipSelect = 1'b1; write = 1'b1; addr = 4'd0; writeData = 32'hAA;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("tx_frozen[%0d]", i), 32'(tx), 32'(wave[9]));
    end
    chipSelect = 1'b0; write = 1'b0;
    en = 1'b1;
    run_wave(10, wave.size() - 1, 1'b0);
    @(negedge clk);
    bus_read(4'd1, rd); check("status_after_freeze", rd, 32'h4);
    bus_read(4'd2, rd); check("baud_after_freeze", rd, 32'd3);

    // asynchronous reset during a start bit with a byte still queued
    b  = 8'($urandom);
    b2 = 8'($urandom);
    bus_write(4'd0, 32'(b));
    bus_write(4'd0, 32'(b2));
    check("tx_start_before_rst", 32'(tx), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("tx_async_rst", 32'(tx), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_read(4'd1, rd); check("status_post_rst", rd, 32'h4);
    bus_read(4'd2, rd); check("baud_post_rst", rd, 32'd434);
    bus_read(4'd3, rd); check("ctrl_post_rst", rd, 32'd0);
    bus_read(4'd4, rd); check("dropcnt_post_rst", rd, 32'd0);
    check("tx_post_rst", 32'(tx), 32'd1);
    check("irq_post_rst", 32'(irq), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
